regfile_bypass: RTL

Parametrised successor to the 16×18-bit processor register file. Provides one synchronous write port and two registered read ports, with optional write-to-read bypass and an optional hard-wired zero register. Also has a background clear sequencer that zeroes the array one entry per cycle under a busy flag. Sits between the decode stage, which supplies read addresses, and the writeback stage, which supplies write address and data, in the 18-bit datapath.

---
 rtl/regfile_bypass.sv | 109 ++++++++++
 1 files changed

// File: rtl/regfile_bypass.sv
// Parametrised register file: one write port, two registered read ports, optional
// write-to-read bypass, optional hard-wired zero entry and a one-entry-per-cycle sweep clear.
module regfile_bypass #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          ZERO_REG   = 1'b0,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clck,
  input  logic                  reset_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] select_register,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] reg_1,
  input  logic [ADDR_WIDTH-1:0] reg_2,
  input  logic                  clear_start,
  output logic [DATA_WIDTH-1:0] read_reg_1_value,
  output logic [DATA_WIDTH-1:0] read_reg_2_value,
  output logic                  read_valid,
  output logic                  clear_busy
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  typedef enum logic {StIdle, StClear} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [Depth];
  logic [DATA_WIDTH-1:0]   mem_d [Depth];
  logic [DATA_WIDTH-1:0]   rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0]   rd2_q, rd2_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;

  // Zero entry wins over bypass; bypass wins over the stored value.
  function automatic logic [DATA_WIDTH-1:0] rd_sel(input logic [ADDR_WIDTH-1:0] addr);
    if (ZERO_REG && (addr == '0)) begin
      return '0;
    end else if (BYPASS && write_enable && (select_register == addr)) begin
      return data;
    end else begin
      return mem_q[addr];
    end
  endfunction

  always_comb begin
    mem_d   = mem_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (write_enable && !(ZERO_REG && (select_register == '0))) begin
          mem_d[select_register] = data;
        end
        if (read_enable) begin
          rd1_d   = rd_sel(reg_1);
          rd2_d   = rd_sel(reg_2);
          valid_d = 1'b1;
        end
        if (clear_start) begin
          state_d = StClear;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StClear: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + 1'b1;
        // Counter wrap marks the last entry; no extra terminal bit needed.
        if (cnt_q == '1) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clck) begin
    if (reset_enable) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mem_q   <= '{default: '0};
      rd1_q   <= '0;
      rd2_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign read_reg_1_value = rd1_q;
  assign read_reg_2_value = rd2_q;
  assign read_valid       = valid_q;
  assign clear_busy       = busy_q;

endmodule
